// File: rtl/seg_scan_decoder.sv
// Receive-side scanned 7-segment decoder.
// Watches a multiplexed common-select 7-segment bus and rebuilds the hex
// nibble shown on every digit, with per-digit valid/error flags, a change
// pulse (update) and a whole-frame pulse (frame_done).
`timescale 1ns/1ps

module seg_scan_decoder #(
    parameter int DIGITS         = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     sel_in,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     digit_error,
    output logic                  update,
    output logic                  frame_done
);

    localparam int                 RUN_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0]   RUN_MAX  = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0]   RUN_ARM  = RUN_W'(STABLE_CYCLES - 1);
    localparam int                 SAMPLE_W = DIGITS + 7;

    // Raw line levels that mean "nothing selected, all segments dark".
    localparam logic [DIGITS-1:0]  SEL_IDLE = {DIGITS{SEL_ACTIVE_LOW}};
    localparam logic [6:0]         SEG_IDLE = {7{SEG_ACTIVE_LOW}};
    localparam logic [6:0]         SEG_DARK = 7'h7F;

    typedef enum logic [1:0] {
        GLYPH_HEX   = 2'd0,
        GLYPH_BLANK = 2'd1,
        GLYPH_ERR   = 2'd2
    } glyph_kind_e;

    typedef struct packed {
        glyph_kind_e kind;
        logic [3:0]  code;
    } glyph_t;

    // Active-low gfedcba pattern to hex nibble; all-dark is a blank digit.
    function automatic glyph_t decode_glyph(input logic [6:0] seg);
        glyph_t g;
        g.kind = GLYPH_HEX;
        g.code = 4'h0;
        case (seg)
            7'h40: g.code = 4'h0;
            7'h79: g.code = 4'h1;
            7'h24: g.code = 4'h2;
            7'h30: g.code = 4'h3;
            7'h19: g.code = 4'h4;
            7'h12: g.code = 4'h5;
            7'h02: g.code = 4'h6;
            7'h78: g.code = 4'h7;
            7'h00: g.code = 4'h8;
            7'h10: g.code = 4'h9;
            7'h08: g.code = 4'hA;
            7'h03: g.code = 4'hB;
            7'h46: g.code = 4'hC;
            7'h21: g.code = 4'hD;
            7'h06: g.code = 4'hE;
            7'h0E: g.code = 4'hF;
            7'h7F: g.kind = GLYPH_BLANK;
            default: g.kind = GLYPH_ERR;
        endcase
        return g;
    endfunction

    // True when exactly one select line is active.
    function automatic logic is_onehot(input logic [DIGITS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < DIGITS; i++) begin
            n = n + 32'(v[i]);
        end
        return (n == 1);
    endfunction

    logic [6:0]            seg_p0, seg_p1;
    logic [DIGITS-1:0]     sel_p0, sel_p1;
    logic [6:0]            seg_n;
    logic [DIGITS-1:0]     sel_n;
    logic [SAMPLE_W-1:0]   sample;
    logic [SAMPLE_W-1:0]   sample_p2;
    logic [RUN_W-1:0]      run;
    logic                  stable;
    logic                  capture;
    glyph_t                glyph;
    logic [4*DIGITS-1:0]   value_nx;
    logic [DIGITS-1:0]     valid_nx;
    logic [DIGITS-1:0]     error_nx;
    logic                  changed;
    logic [DIGITS-1:0]     seen;
    logic [DIGITS-1:0]     seen_nx;

    // Two-flop synchroniser; reset parks it at the idle bus level so the
    // first real sample after reset always looks like a change.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_p0 <= SEG_IDLE;
            seg_p1 <= SEG_IDLE;
            sel_p0 <= SEL_IDLE;
            sel_p1 <= SEL_IDLE;
        end else begin
            seg_p0 <= seg_in;
            seg_p1 <= seg_p0;
            sel_p0 <= sel_in;
            sel_p1 <= sel_p0;
        end
    end

    // Normalise polarity: one-hot active-high select, active-low segments.
    always_comb begin
        seg_n  = SEG_ACTIVE_LOW ? seg_p1 : ~seg_p1;
        sel_n  = SEL_ACTIVE_LOW ? ~sel_p1 : sel_p1;
        sample = {sel_n, seg_n};
        stable = (sample == sample_p2);
        // Fire only on the transition into the saturated count, so a held
        // sample captures once and never again until it changes.
        capture = stable && (run == RUN_ARM) && is_onehot(sel_n);
    end

    // Stability tracker: previous sample and saturating run-length counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_p2 <= {{DIGITS{1'b0}}, SEG_DARK};
            run       <= '0;
        end else begin
            sample_p2 <= sample;
            if (!stable) begin
                run <= RUN_W'(1);
            end else if (run != RUN_MAX) begin
                run <= run + RUN_W'(1);
            end
        end
    end

    // Next digit state for a capture; blank and error keep the old nibble.
    always_comb begin
        value_nx = value;
        valid_nx = digit_valid;
        error_nx = digit_error;
        glyph    = decode_glyph(seg_n);
        if (capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (sel_n[i]) begin
                    case (glyph.kind)
                        GLYPH_HEX: begin
                            value_nx[4*i +: 4] = glyph.code;
                            valid_nx[i]        = 1'b1;
                            error_nx[i]        = 1'b0;
                        end
                        GLYPH_BLANK: begin
                            valid_nx[i] = 1'b0;
                            error_nx[i] = 1'b0;
                        end
                        default: begin
                            valid_nx[i] = 1'b0;
                            error_nx[i] = 1'b1;
                        end
                    endcase
                end
            end
        end
        changed = (value_nx != value) || (valid_nx != digit_valid) ||
                  (error_nx != digit_error);
    end

    // Frame tracking: a full mask is reported for one cycle and then
    // restarted, keeping any capture that lands in that same cycle.
    always_comb begin
        seen_nx = frame_done ? '0 : seen;
        if (capture) begin
            seen_nx = seen_nx | sel_n;
        end
    end

    assign frame_done = &seen;

    // Output registers and change pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            value       <= '0;
            digit_valid <= '0;
            digit_error <= '0;
            update      <= 1'b0;
            seen        <= '0;
        end else begin
            value       <= value_nx;
            digit_valid <= valid_nx;
            digit_error <= error_nx;
            update      <= changed;
            seen        <= seen_nx;
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with default parameters.
`timescale 1ns/1ps

module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in = 7'h7F;
    logic [3:0]  sel_in = 4'hF;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic [3:0]  digit_error;
    logic        update;
    logic        frame_done;

    int n_cmp = 0;
    int n_mis = 0;

    // Observed bundle: value, valid, error, update, frame_done.
    logic [25:0] obs;
    logic [25:0] exp_b;
    logic [15:0] exp_val;
    logic [3:0]  exp_vld;

    assign obs = {value, digit_valid, digit_error, update, frame_done};

    seg_scan_decoder #(
        .DIGITS(4),
        .STABLE_CYCLES(4),
        .SEG_ACTIVE_LOW(1'b1),
        .SEL_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .seg_in(seg_in),
        .sel_in(sel_in),
        .value(value),
        .digit_valid(digit_valid),
        .digit_error(digit_error),
        .update(update),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle at the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        seg_in = 7'h7F;
        sel_in = 4'hF;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (obs !== 26'h0) begin
            n_mis++;
            $display("FAIL reset: got %h want %h", obs, 26'h0);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (obs !== 26'h0) begin
            n_mis++;
            $display("FAIL reset_release: got %h want %h", obs, 26'h0);
        end
    endtask

    task automatic test_single_digit();
        sel_in = 4'b1110;
        seg_in = 7'h79;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp_b = (e >= 6) ? {16'h0001, 4'b0001, 4'b0000, (e == 6), 1'b0}
                             : 26'h0;
            n_cmp++;
            if (obs !== exp_b) begin
                n_mis++;
                $display("FAIL single_digit edge %0d: got %h want %h", e, obs, exp_b);
            end
        end
    endtask

    task automatic test_glitch_reject();
        int upd_cnt;
        upd_cnt = 0;
        sel_in = 4'b1101;
        seg_in = 7'h24;
        for (int e = 1; e <= 3; e++) begin
            tick();
            upd_cnt += int'(update);
            exp_b = {16'h0001, 4'b0001, 4'b0000, 1'b0, 1'b0};
            n_cmp++;
            if (obs !== exp_b) begin
                n_mis++;
                $display("FAIL glitch_hold edge %0d: got %h want %h", e, obs, exp_b);
            end
        end
        seg_in = 7'h30;
        for (int e = 1; e <= 8; e++) begin
            tick();
            upd_cnt += int'(update);
            exp_b = (e >= 6) ? {16'h0031, 4'b0011, 4'b0000, (e == 6), 1'b0}
                             : {16'h0001, 4'b0001, 4'b0000, 1'b0, 1'b0};
            n_cmp++;
            if (obs !== exp_b) begin
                n_mis++;
                $display("FAIL glitch_settle edge %0d: got %h want %h", e, obs, exp_b);
            end
        end
        n_cmp++;
        if (upd_cnt != 1) begin
            n_mis++;
            $display("FAIL glitch_update_count: got %0d want 1", upd_cnt);
        end
    endtask

    task automatic test_scan();
        logic [6:0] codes [4];
        codes[0] = 7'h79;
        codes[1] = 7'h24;
        codes[2] = 7'h30;
        codes[3] = 7'h19;
        do_reset();
        exp_val = 16'h0000;
        exp_vld = 4'b0000;
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < 4; p++) begin
                sel_in = ~(4'b0001 << p);
                seg_in = codes[p];
                for (int e = 1; e <= 8; e++) begin
                    tick();
                    if (e == 6) begin
                        exp_val[4*p +: 4] = 4'(p + 1);
                        exp_vld[p] = 1'b1;
                    end
                    exp_b = {exp_val, exp_vld, 4'b0000,
                             (s == 0 && e == 6), (p == 3 && e == 6)};
                    n_cmp++;
                    if (obs !== exp_b) begin
                        n_mis++;
                        $display("FAIL scan s%0d d%0d edge %0d: got %h want %h",
                                 s, p, e, obs, exp_b);
                    end
                end
            end
        end
        n_cmp++;
        if (value !== 16'h4321 || digit_valid !== 4'b1111) begin
            n_mis++;
            $display("FAIL scan_final: got %h/%b want 4321/1111", value, digit_valid);
        end
    endtask

    task automatic test_blank_error();
        sel_in = 4'b1011;
        seg_in = 7'h7E;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_b = (e >= 6) ? {16'h4321, 4'b1011, 4'b0100, (e == 6), 1'b0}
                             : {16'h4321, 4'b1111, 4'b0000, 1'b0, 1'b0};
            n_cmp++;
            if (obs !== exp_b) begin
                n_mis++;
                $display("FAIL error_glyph edge %0d: got %h want %h", e, obs, exp_b);
            end
        end
        seg_in = 7'h7F;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_b = (e >= 6) ? {16'h4321, 4'b1011, 4'b0000, (e == 6), 1'b0}
                             : {16'h4321, 4'b1011, 4'b0100, 1'b0, 1'b0};
            n_cmp++;
            if (obs !== exp_b) begin
                n_mis++;
                $display("FAIL blank_glyph edge %0d: got %h want %h", e, obs, exp_b);
            end
        end
    endtask

    task automatic test_bad_select();
        logic [3:0] pats [2];
        pats[0] = 4'b1100;
        pats[1] = 4'b1111;
        seg_in = 7'h12;
        for (int k = 0; k < 2; k++) begin
            sel_in = pats[k];
            for (int e = 1; e <= 20; e++) begin
                tick();
                exp_b = {16'h4321, 4'b1011, 4'b0000, 1'b0, 1'b0};
                n_cmp++;
                if (obs !== exp_b) begin
                    n_mis++;
                    $display("FAIL bad_select %b edge %0d: got %h want %h",
                             pats[k], e, obs, exp_b);
                end
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        sel_in = 4'b1110;
        seg_in = 7'h12;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (obs !== 26'h0) begin
            n_mis++;
            $display("FAIL mid_hold_reset: got %h want %h", obs, 26'h0);
        end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_b = (e >= 6) ? {16'h0005, 4'b0001, 4'b0000, (e == 6), 1'b0}
                             : 26'h0;
            n_cmp++;
            if (obs !== exp_b) begin
                n_mis++;
                $display("FAIL mid_hold_release edge %0d: got %h want %h", e, obs, exp_b);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_digit();
        test_glitch_reject();
        test_scan();
        test_blank_error();
        test_bad_select();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
